// File: rtl/store_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_trace_buffer_if
//  Description : Bundles the signals of store_trace_buffer:
//                - store bus (observed RAM writes)
//                - trace control (arm, trigger, capture window)
//                - read-out port and status
//                Master modport: the controlling side. Slave modport: the
//                trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_trace_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // observed store bus
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [15:0]       pc;

  // trace control
  logic              arm;
  logic              trig;
  logic [ADDR_W-1:0] win_lo;
  logic [ADDR_W-1:0] win_hi;

  // read-out port
  logic              rd_req;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       rd_pc;

  // status
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic              overflow;

  modport master (
    output mem_we, mem_addr, mem_wdata, pc, arm, trig, win_lo, win_hi, rd_req,
    input  rd_valid, rd_addr, rd_data, rd_pc, count, state, overflow
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, pc, arm, trig, win_lo, win_hi, rd_req,
    output rd_valid, rd_addr, rd_data, rd_pc, count, state, overflow
  );
endinterface
`default_nettype wire

// File: rtl/store_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_trace_buffer
//  Description : Circular trace of datapath RAM stores (address, data, pc).
//                arm clears and starts capture; trig starts a post-trigger
//                countdown after which capture freezes and the buffer can be
//                popped oldest-first.
//
//                Build option:
//                STORE_TRACE_WINDOW_EN
//                  - restricts capture to stores with win_lo <= addr <= win_hi
//                  - when undefined, every store qualifies
//  Revision    : 1.0 - initial release
// ============================================================================
module store_trace_buffer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input wire clk,
  input wire reset,
  store_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_POST_INIT = PTR_W'(POST_TRIG);
  localparam logic [PTR_W-1:0] C_POST_LAST = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  post_cnt_q, post_cnt_d;
  logic              overflow_q, overflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]       rd_pc_q, rd_pc_d;

  logic              win_hit;
  logic              wr_en;

  // trace storage: contents are never observable while count is zero
  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [15:0]       buf_pc_q   [DEPTH];

`ifdef STORE_TRACE_WINDOW_EN
  // inclusive unsigned window; an inverted window matches nothing
  assign win_hit = (bus.mem_addr >= bus.win_lo) && (bus.mem_addr <= bus.win_hi);
`else
  logic unused_win;
  assign win_hit    = 1'b1;
  assign unused_win = ^{bus.win_lo, bus.win_hi};
`endif

  // next-state, capture and pop decisions
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_pc_d    = rd_pc_q;
    wr_en      = 1'b0;

    if (bus.arm) begin
      // arm wins over everything else on the same cycle
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if ((state_q == ST_ARMED || state_q == ST_POST) && bus.mem_we && win_hit) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == C_FULL) begin
          // full: the write lands on the oldest entry, so drop it
          rd_ptr_d   = rd_ptr_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          // a store on the trigger cycle is captured but not counted
          if (bus.trig) begin
            if (POST_TRIG == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_POST;
              post_cnt_d = C_POST_INIT;
            end
          end
        end
        ST_POST: begin
          if (wr_en) begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == C_POST_LAST) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.rd_req && (count_q != '0)) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = buf_addr_q[rd_ptr_q];
            rd_data_d  = buf_data_q[rd_ptr_q];
            rd_pc_d    = buf_pc_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // control and read-out registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_pc_q    <= rd_pc_d;
    end
  end

  // storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_addr_q[wr_ptr_q] <= bus.mem_addr;
      buf_data_q[wr_ptr_q] <= bus.mem_wdata;
      buf_pc_q[wr_ptr_q]   <= bus.pc;
    end
  end

  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_pc    = rd_pc_q;

endmodule
`default_nettype wire
